// File: rtl/mem_stage.sv
// mem_stage: RV64 memory stage (bus handshake, lane alignment, load extension, misalignment traps).
// Optional MEM_MMIO_SKIP_EN registers out_skip for completed accesses below 0x8000_0000.
package mem_pkg;
    typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;
    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        msize_t msize;
        logic   mem_unsigned;
    } control_t;
    typedef struct packed {
        logic        enable;
        logic [63:0] mcause;
        logic [63:0] mtval;
        logic [63:0] mepc;
    } excep_t;
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        control_t    ctl;
        logic [4:0]  dst;
        logic [63:0] aluout;
        logic [63:0] memwd;
        logic [11:0] csraddr;
        logic [63:0] csrdata;
        excep_t      excep;
        logic [1:0]  priviledgeMode;
    } execute_data_t;
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        control_t    ctl;
        logic [4:0]  dst;
        logic [63:0] writedata;
        logic [63:0] memaddr;
        logic [11:0] csraddr;
        logic [63:0] csrdata;
        excep_t      excep;
        logic [1:0]  priviledgeMode;
    } memory_data_t;
endpackage

module mem_stage import mem_pkg::*; #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  execute_data_t     in_data,
    input  logic              flush,
    output logic              mem_stall,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output memory_data_t      out_data,
    output logic              out_skip
);
    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
    state_t       state_q, state_d;
    logic         killed_q, killed_d;
    memory_data_t out_q, out_d;
    logic [2:0]   off;
    logic [5:0]   sh;
    logic [7:0]   strb;
    logic [63:0]  shifted, load_val;
    logic         is_mem, aligned, mem_op, misaligned, active, accept, done, drop;

    always_comb begin
        off = in_data.aluout[2:0];
        sh = {off, 3'b000};
        is_mem = in_data.valid & (in_data.ctl.memread | in_data.ctl.memwrite) & !in_data.excep.enable;
        aligned = in_data.ctl.msize == MSIZE8 ? off == 3'd0 :
                  in_data.ctl.msize == MSIZE4 ? off[1:0] == 2'd0 :
                  in_data.ctl.msize == MSIZE2 ? !off[0] : 1'b1;
        mem_op = is_mem & aligned;
        misaligned = is_mem & !aligned;
        // an access is live while outside IDLE, or in IDLE the cycle a memory op arrives
        active = (state_q != IDLE) | mem_op;
        accept = (state_q == DATA) | dresp_addr_ok;
        done = active & accept & dresp_data_ok;
        drop = active & (state_q != DATA) & flush & !dresp_addr_ok;
        mem_stall = active & !done & !drop;
        dreq_valid = ((state_q == IDLE) & mem_op) | (state_q == REQ);
        dreq_addr = in_data.aluout[ADDR_W-1:0];
        dreq_size = in_data.ctl.msize;
        strb = in_data.ctl.msize == MSIZE8 ? 8'hFF : in_data.ctl.msize == MSIZE4 ? 8'h0F :
               in_data.ctl.msize == MSIZE2 ? 8'h03 : 8'h01;
        dreq_strobe = in_data.ctl.memwrite ? strb << off : 8'h00;
        dreq_data = in_data.memwd << sh;
        shifted = dresp_data >> sh;
        load_val = in_data.ctl.msize == MSIZE8 ? shifted :
                   in_data.ctl.msize == MSIZE4 ? {{32{!in_data.ctl.mem_unsigned & shifted[31]}}, shifted[31:0]} :
                   in_data.ctl.msize == MSIZE2 ? {{48{!in_data.ctl.mem_unsigned & shifted[15]}}, shifted[15:0]} :
                   {{56{!in_data.ctl.mem_unsigned & shifted[7]}}, shifted[7:0]};
        state_d = (done | drop) ? IDLE : (active & accept) ? DATA : active ? REQ : IDLE;
        killed_d = (done | drop) ? 1'b0 : killed_q | (active & flush);
        out_d.valid = done ? !killed_q & !flush : !active & in_data.valid & !flush;
        out_d.pc = in_data.pc;
        out_d.raw_instr = in_data.raw_instr;
        out_d.ctl = in_data.ctl;
        out_d.dst = in_data.dst;
        out_d.writedata = done ? (in_data.ctl.memwrite ? 64'd0 : load_val) : in_data.aluout;
        out_d.memaddr = in_data.aluout;
        out_d.csraddr = in_data.csraddr;
        out_d.csrdata = in_data.csrdata;
        out_d.excep = in_data.excep;
        out_d.priviledgeMode = in_data.priviledgeMode;
        if (misaligned) begin
            out_d.excep.enable = 1'b1;
            out_d.excep.mcause = in_data.ctl.memwrite ? 64'd6 : 64'd4;
            out_d.excep.mtval = in_data.aluout;
            out_d.excep.mepc = in_data.pc;
            out_d.ctl.regwrite = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            killed_q <= 1'b0;
            out_q <= '0;
        end else begin
            state_q <= state_d;
            killed_q <= killed_d;
            out_q <= out_d;
        end
    end

    assign out_data = out_q;

`ifdef MEM_MMIO_SKIP_EN
    logic skip_q, skip_d;
    assign skip_d = done & !killed_q & !flush & !in_data.aluout[31];
    always_ff @(posedge clk) begin
        if (reset) skip_q <= 1'b0;
        else skip_q <= skip_d;
    end
    assign out_skip = skip_q;
`else
    assign out_skip = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage with directed corner cases.
module tb_mem_stage;
    import mem_pkg::*;
    logic          clk = 1'b0, reset = 1'b1, flush = 1'b0;
    execute_data_t in_data = '0;
    logic          mem_stall, dreq_valid, out_skip;
    logic [63:0]   dreq_addr, dreq_data, dresp_data = '0;
    logic [2:0]    dreq_size;
    logic [7:0]    dreq_strobe;
    logic          dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0;
    memory_data_t  out_data;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .in_data(in_data), .flush(flush),
        .mem_stall(mem_stall), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_data(out_data), .out_skip(out_skip)
    );

    memory_data_t exp_q[$];
    logic         exp_skip_q[$];
    memory_data_t mon_exp, last_out;
    logic         mon_skip, last_skip;
    int           n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_data.valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_unexpected: got valid output pc %h with nothing expected", out_data.pc);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_skip = exp_skip_q.pop_front();
                if (out_data !== mon_exp || out_skip !== mon_skip) begin
                    n_err++;
                    $display("FAIL out_data: got %h skip %b want %h skip %b", out_data, out_skip, mon_exp, mon_skip);
                end
            end
            last_out = out_data;
            last_skip = out_skip;
        end
    end

    function automatic bit is_acc(input execute_data_t e);
        return e.valid && (e.ctl.memread || e.ctl.memwrite) && !e.excep.enable;
    endfunction

    // reference: what writeback should see, from the architectural rules
    function automatic memory_data_t model(input execute_data_t e, input logic [63:0] rd);
        memory_data_t r;
        int n = 1 << int'(e.ctl.msize);
        int off = int'(e.aluout[2:0]);
        logic [63:0] mask, v;
        r.valid = 1'b1; r.pc = e.pc; r.raw_instr = e.raw_instr; r.ctl = e.ctl; r.dst = e.dst;
        r.writedata = e.aluout; r.memaddr = e.aluout; r.csraddr = e.csraddr; r.csrdata = e.csrdata;
        r.excep = e.excep; r.priviledgeMode = e.priviledgeMode;
        if (is_acc(e)) begin
            if (off % n != 0) begin
                r.excep.enable = 1'b1;
                r.excep.mcause = e.ctl.memwrite ? 64'd6 : 64'd4;
                r.excep.mtval = e.aluout;
                r.excep.mepc = e.pc;
                r.ctl.regwrite = 1'b0;
            end else if (e.ctl.memwrite) begin
                r.writedata = 64'd0;
            end else begin
                mask = (n == 8) ? '1 : (64'd1 << (8 * n)) - 64'd1;
                v = (rd >> (8 * off)) & mask;
                if (!e.ctl.mem_unsigned && n < 8 && v[8*n-1]) v = v | ~mask;
                r.writedata = v;
            end
        end
        return r;
    endfunction

    function automatic execute_data_t mk(input int kind, input logic [63:0] addr, input logic [63:0] wd,
                                         input msize_t sz, input bit uns);
        execute_data_t e = '0;
        e.valid = 1'b1;
        e.pc = {32'h0, $urandom} & ~64'h3;
        e.raw_instr = $urandom;
        e.dst = 5'($urandom);
        e.csraddr = 12'($urandom);
        e.csrdata = {$urandom, $urandom};
        e.priviledgeMode = 2'($urandom);
        e.aluout = addr;
        e.memwd = wd;
        e.ctl.msize = sz;
        e.ctl.mem_unsigned = uns;
        e.ctl.regwrite = kind != 2;
        e.ctl.memread = kind == 1;
        e.ctl.memwrite = kind == 2;
        return e;
    endfunction

    // drive one instruction; al/dl = addr_ok and data_ok delays, fl = cycle of flush (-1 none)
    task automatic run(input execute_data_t e, input logic [63:0] rd, input int al, input int dl, input int fl);
        int  n = 1 << int'(e.ctl.msize);
        int  off = int'(e.aluout[2:0]);
        bit  mem = is_acc(e) && (off % n == 0);
        int  fin = al + dl;
        bit  dropped = mem && fl >= 0 && fl < al;
        bit  killed = mem ? (fl >= 0 && fl <= fin) : (fl == 0);
        logic [7:0]  strb = e.ctl.memwrite ? 8'((((1 << n) - 1) << off)) : 8'h00;
        logic [63:0] sdata = e.memwd << (8 * off);
        if (e.valid && !killed) begin
            exp_q.push_back(model(e, rd));
`ifdef MEM_MMIO_SKIP_EN
            exp_skip_q.push_back(mem && !e.aluout[31]);
`else
            exp_skip_q.push_back(1'b0);
`endif
        end
        in_data = e;
        for (int k = 0; k <= (mem ? fin : 0); k++) begin
            flush = (k == fl);
            dresp_addr_ok = mem && k == al;
            dresp_data_ok = mem && k == fin;
            dresp_data = rd;
            @(negedge clk);
            chk("mem_stall", 64'(mem_stall), 64'(mem && k != fin && !(dropped && k == fl)));
            chk("dreq_valid", 64'(dreq_valid), 64'(mem && k <= al));
            if (mem && k <= al) begin
                chk("dreq_addr", dreq_addr, e.aluout);
                chk("dreq_size", 64'(dreq_size), 64'(e.ctl.msize));
                chk("dreq_strobe", 64'(dreq_strobe), 64'(strb));
                chk("dreq_data", dreq_data, sdata);
            end
            @(posedge clk);
            #1;
            if (dropped && k == fl) break;
        end
        in_data.valid = 1'b0;
        flush = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
    endtask

    task automatic settle(output memory_data_t o, output logic s);
        @(negedge clk);
        #1;
        o = last_out;
        s = last_skip;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    initial begin
        memory_data_t o;
        logic s;
        execute_data_t e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_data.valid), 64'd0);
        chk("reset_dreq_valid", 64'(dreq_valid), 64'd0);
        chk("reset_mem_stall", 64'(mem_stall), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        run(mk(0, 64'h1234, 64'h0, MSIZE8, 1'b0), 64'h0, 0, 0, -1);
        settle(o, s);
        chk("addi_wd", o.writedata, 64'h1234);

        run(mk(1, 64'h80000003, 64'h0, MSIZE1, 1'b0), 64'h00000000_80FF0000, 1, 2, -1);
        settle(o, s);
        chk("lb_wd", o.writedata, 64'hFFFFFFFF_FFFFFF80);
        run(mk(1, 64'h80000003, 64'h0, MSIZE1, 1'b1), 64'h00000000_80FF0000, 1, 2, -1);
        settle(o, s);
        chk("lbu_wd", o.writedata, 64'h80);

        e = mk(2, 64'h80000006, 64'hBEEF, MSIZE2, 1'b0);
        in_data = e;
        @(negedge clk);
        chk("sh_strobe", 64'(dreq_strobe), 64'hC0);
        chk("sh_data", dreq_data, 64'hBEEF0000_00000000);
        chk("sh_size", 64'(dreq_size), 64'(MSIZE2));
        @(posedge clk);
        #1;
        run(e, 64'h0, 1, 1, -1);
        settle(o, s);
        chk("sh_wd", o.writedata, 64'h0);

        e = mk(1, 64'h80000002, 64'h0, MSIZE4, 1'b0);
        run(e, 64'h0, 0, 0, -1);
        settle(o, s);
        chk("lw_mis_en", 64'(o.excep.enable), 64'd1);
        chk("lw_mis_cause", o.excep.mcause, 64'd4);
        chk("lw_mis_tval", o.excep.mtval, 64'h80000002);
        chk("lw_mis_epc", o.excep.mepc, e.pc);
        run(mk(2, 64'h80000004, 64'h55, MSIZE8, 1'b0), 64'h0, 0, 0, -1);
        settle(o, s);
        chk("sd_mis_cause", o.excep.mcause, 64'd6);

        run(mk(1, 64'h80000010, 64'h0, MSIZE8, 1'b0), 64'h1122334455667788, 0, 3, 1);
        run(mk(0, 64'hABCD, 64'h0, MSIZE8, 1'b0), 64'h0, 0, 0, -1);
        settle(o, s);
        chk("after_flush_wd", o.writedata, 64'hABCD);

        in_data = mk(1, 64'h80000020, 64'h0, MSIZE8, 1'b0);
        @(negedge clk);
        chk("rst_req_dreq0", 64'(dreq_valid), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_dreq1", 64'(dreq_valid), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_data.valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_dreq", 64'(dreq_valid), 64'd0);
        chk("rst_req_stall", 64'(mem_stall), 64'd0);
        @(posedge clk);
        #1;

        run(mk(1, 64'h40000000, 64'h0, MSIZE4, 1'b0), 64'hDEADBEEF_12345678, 0, 1, -1);
        settle(o, s);
`ifdef MEM_MMIO_SKIP_EN
        chk("skip_mmio", 64'(s), 64'd1);
`else
        chk("skip_mmio", 64'(s), 64'd0);
`endif
        run(mk(1, 64'h80000000, 64'h0, MSIZE4, 1'b0), 64'hDEADBEEF_12345678, 0, 1, -1);
        settle(o, s);
        chk("skip_ram", 64'(s), 64'd0);

        for (int i = 0; i < 400; i++) begin
            int     kind = $urandom_range(0, 9);
            msize_t sz = msize_t'($urandom_range(0, 3));
            logic [63:0] a = {32'h0, $urandom};
            int     fl = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 5) : -1;
            if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << int'(sz)) - 1);
            e = mk(kind <= 2 ? 0 : (kind <= 5 || kind >= 8) ? 1 : 2, a, {$urandom, $urandom}, sz, 1'($urandom));
            if (kind == 8) begin
                e.excep.enable = 1'b1;
                e.excep.mcause = 64'($urandom_range(0, 15));
                e.excep.mepc = e.pc;
            end
            if (kind == 9) e.valid = 1'b0;
            run(e, {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3), fl);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
